// File: rtl/inccomp_pkg.sv
// rtl/inccomp_pkg.sv - shared state encoding and defaults for inccomp driver and bench
package inccomp_pkg;
  localparam int WIDTH_DEF  = 8;
  localparam int SETTLE_DEF = 2;
  // settle counter only needs to hold 1..15
  localparam int SCNT_W     = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_SETTLE,
    ST_DONE
  } state_e;
endpackage

// File: rtl/inccomp_driver_if.sv
// rtl/inccomp_driver_if.sv - request/drive/result bundle between a host and inccomp_driver
interface inccomp_driver_if import inccomp_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF
);
  logic             start;
  logic [WIDTH-1:0] len_a;
  logic [WIDTH-1:0] len_b;
  logic [WIDTH-1:0] delay_b;
  logic [WIDTH-1:0] expected;
  logic [WIDTH-1:0] c;
  logic             inca;
  logic             incb;
  logic             busy;
  logic             done;
  logic             pass;

  modport master (
    input  start, len_a, len_b, delay_b, expected, c,
    output inca, incb, busy, done, pass
  );

  modport slave (
    output start, len_a, len_b, delay_b, expected, c,
    input  inca, incb, busy, done, pass
  );
endinterface

// File: rtl/inccomp_driver_down_cnt.sv
// rtl/inccomp_driver_down_cnt.sv - loadable down-counter that saturates at zero
module down_cnt #(
  parameter int W = 8
) (
  input  logic         ck,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o,
  output logic         zero_o,
  output logic         zero_next_o
);
  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // load wins over decrement; decrement never wraps past zero
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o       = cnt_q;
  assign zero_o      = (cnt_q == '0);
  assign zero_next_o = (cnt_d == '0);
endmodule

// File: rtl/inccomp_driver.sv
// rtl/inccomp_driver.sv - drives INCA/INCB pulse trains into inccomp and checks its C output
module inccomp_driver import inccomp_pkg::*; #(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int SETTLE = SETTLE_DEF
) (
  input  logic ck,
  input  logic rst,
  inccomp_driver_if.master bus
);
  state_e           state_q;
  logic             pass_q;
  logic [WIDTH-1:0] exp_q;

  logic             a_zero, a_zero_nx;
  logic             b_zero, b_zero_nx;
  logic             dly_zero;
  logic [SCNT_W-1:0] scnt;
  logic [WIDTH-1:0] cnt_a_unused, cnt_b_unused, dly_unused;
  logic             dly_unused_nx, scnt_unused_zero, scnt_unused_nx;

  logic accept, in_run, in_settle, zero_len, run_end, settle_last;

  assign accept      = (state_q == ST_IDLE) && bus.start;
  assign in_run      = (state_q == ST_RUN);
  assign in_settle   = (state_q == ST_SETTLE);
  assign zero_len    = (bus.len_a == '0) && (bus.len_b == '0);
  // a pending delay with nothing left on B does not keep RUN alive
  assign run_end     = in_run && a_zero_nx && b_zero_nx;
  assign settle_last = in_settle && (scnt == SCNT_W'(1));

  down_cnt #(.W(WIDTH)) u_cnt_a (
    .ck(ck), .rst(rst),
    .load_i(accept), .load_val_i(bus.len_a), .en_i(in_run),
    .cnt_o(cnt_a_unused), .zero_o(a_zero), .zero_next_o(a_zero_nx)
  );

  down_cnt #(.W(WIDTH)) u_cnt_b (
    .ck(ck), .rst(rst),
    .load_i(accept), .load_val_i(bus.len_b), .en_i(in_run && dly_zero),
    .cnt_o(cnt_b_unused), .zero_o(b_zero), .zero_next_o(b_zero_nx)
  );

  down_cnt #(.W(WIDTH)) u_dly (
    .ck(ck), .rst(rst),
    .load_i(accept), .load_val_i(bus.delay_b), .en_i(in_run),
    .cnt_o(dly_unused), .zero_o(dly_zero), .zero_next_o(dly_unused_nx)
  );

  down_cnt #(.W(SCNT_W)) u_scnt (
    .ck(ck), .rst(rst),
    .load_i((accept && zero_len) || run_end), .load_val_i(SCNT_W'(SETTLE)),
    .en_i(in_settle),
    .cnt_o(scnt), .zero_o(scnt_unused_zero), .zero_next_o(scnt_unused_nx)
  );

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pass_q  <= 1'b0;
      exp_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            exp_q   <= bus.expected;
            pass_q  <= 1'b0;
            state_q <= zero_len ? ST_SETTLE : ST_RUN;
          end
        end
        ST_RUN: begin
          if (run_end) begin
            state_q <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (settle_last) begin
            pass_q  <= (bus.c == exp_q);
            state_q <= ST_DONE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // pulse outputs decode straight from registered state so they fall with rst
  assign bus.inca = in_run && !a_zero;
  assign bus.incb = in_run && dly_zero && !b_zero;
  assign bus.busy = (state_q != ST_IDLE);
  assign bus.done = (state_q == ST_DONE);
  assign bus.pass = pass_q;
endmodule

// File: tb/tb_inccomp_driver.sv
// tb/tb_inccomp_driver.sv - scoreboard bench for inccomp_driver
module tb_inccomp_driver;
  typedef struct {
    int la;
    int lb;
    int db;
    int dc;
    bit pv;
    int t0;
  } rec_t;

  logic ck;
  logic rst;
  int   tick;
  int   total;
  int   bad;
  bit   idle_pass;
  rec_t sb[$];

  inccomp_driver_if #(.WIDTH(8)) bus ();

  inccomp_driver #(.WIDTH(8), .SETTLE(2)) dut (
    .ck(ck),
    .rst(rst),
    .bus(bus)
  );

  initial begin
    ck = 1'b0;
    forever #5 ck = ~ck;
  end

  always @(posedge ck) tick <= tick + 1;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at t=%0t", n, act, req, $time);
    end
  endtask

  // one record per accepted run; position in the run is derived from tick
  always @(negedge ck) begin
    rec_t r;
    int   rel;
    if (sb.size() == 0) begin
      chk("idle_inca", {31'b0, bus.inca}, 0);
      chk("idle_incb", {31'b0, bus.incb}, 0);
      chk("idle_busy", {31'b0, bus.busy}, 0);
      chk("idle_done", {31'b0, bus.done}, 0);
      chk("idle_pass", {31'b0, bus.pass}, {31'b0, idle_pass});
    end else begin
      r   = sb[0];
      rel = tick - r.t0 + 1;
      chk("inca", {31'b0, bus.inca}, {31'b0, (rel >= 1 && rel <= r.la)});
      chk("incb", {31'b0, bus.incb}, {31'b0, (rel > r.db && rel <= r.db + r.lb)});
      chk("busy", {31'b0, bus.busy}, {31'b0, (rel >= 1 && rel <= r.dc)});
      chk("done", {31'b0, bus.done}, {31'b0, (rel == r.dc)});
      if (rel >= r.dc) begin
        chk("pass", {31'b0, bus.pass}, {31'b0, r.pv});
        idle_pass = r.pv;
        void'(sb.pop_front());
      end else begin
        chk("run_pass", {31'b0, bus.pass}, 0);
      end
    end
  end

  // mode 0: plain run, 1: stray start in cycle 2, 2: reset in cycle 2
  task automatic run_vec(input int la, input int lb, input int db, input logic [7:0] ex,
                         input logic [7:0] cv, input int dc, input bit pv, input int mode);
    rec_t r;
    bus.len_a    = 8'(la);
    bus.len_b    = 8'(lb);
    bus.delay_b  = 8'(db);
    bus.expected = ex;
    bus.c        = cv;
    bus.start    = 1'b1;
    @(posedge ck);
    #1;
    r.la = la; r.lb = lb; r.db = db; r.dc = dc; r.pv = pv; r.t0 = tick;
    sb.push_back(r);
    bus.start = 1'b0;
    if (mode == 1) begin
      @(posedge ck);
      #1;
      bus.start    = 1'b1;
      bus.len_a    = 8'd9;
      bus.len_b    = 8'd9;
      bus.delay_b  = 8'd0;
      bus.expected = 8'hFF;
      @(posedge ck);
      #1;
      bus.start = 1'b0;
    end
    if (mode == 2) begin
      @(posedge ck);
      #1;
      sb.delete();
      idle_pass = 1'b0;
      rst = 1'b1;
      #1;
      chk("rst_inca", {31'b0, bus.inca}, 0);
      chk("rst_incb", {31'b0, bus.incb}, 0);
      chk("rst_busy", {31'b0, bus.busy}, 0);
      repeat (2) @(posedge ck);
      #1;
      rst = 1'b0;
      repeat (4) @(posedge ck);
      #1;
    end else begin
      for (int i = 0; i < 40 && sb.size() != 0; i++) @(posedge ck);
      #1;
      chk("run_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  initial begin
    total        = 0;
    bad          = 0;
    tick         = 0;
    idle_pass    = 1'b0;
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.len_a    = '0;
    bus.len_b    = '0;
    bus.delay_b  = '0;
    bus.expected = '0;
    bus.c        = '0;
    #1;
    chk("reset_inca", {31'b0, bus.inca}, 0);
    chk("reset_incb", {31'b0, bus.incb}, 0);
    chk("reset_busy", {31'b0, bus.busy}, 0);
    chk("reset_done", {31'b0, bus.done}, 0);
    chk("reset_pass", {31'b0, bus.pass}, 0);
    repeat (3) @(posedge ck);
    #1;
    rst = 1'b0;
    @(posedge ck);
    #1;

    run_vec(3, 2, 1, 8'h05, 8'h05, 6, 1'b1, 0);
    run_vec(3, 2, 1, 8'h05, 8'h04, 6, 1'b0, 0);
    repeat (3) @(posedge ck);
    #1;
    run_vec(0, 0, 7, 8'h00, 8'h00, 3, 1'b1, 0);
    run_vec(2, 3, 4, 8'h11, 8'h11, 10, 1'b1, 0);
    run_vec(3, 2, 1, 8'h05, 8'h05, 6, 1'b1, 1);
    run_vec(2, 3, 4, 8'h11, 8'h12, 10, 1'b0, 0);
    run_vec(3, 2, 1, 8'h05, 8'h05, 6, 1'b1, 2);
    run_vec(0, 2, 0, 8'h3C, 8'h3C, 5, 1'b1, 0);
    run_vec(4, 0, 9, 8'hA0, 8'hA0, 7, 1'b1, 0);
    repeat (2) @(posedge ck);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
